// File: rtl/basket_accumulator.sv
// Purpose: multi-product basket engine; per-ID quantity table, running total, line count, checkout lock.
// Latency: add/remove 3 cycles (DONE/ERR at T+3), early rejects and checkout 1 cycle, clear NUM_PRODUCTS+1 cycles.
// Backpressure: BUSY high while a command runs; ENABLE seen while BUSY is dropped without any response.
//
// Ports:
//   CLOCK_50, RESET_N         clock (rising edge) and asynchronous active-low reset
//   ENABLE, CMD               one-cycle command strobe; 00 add, 01 remove, 10 clear, 11 checkout
//   PRODUCT_ID, QUANTITY      command operands, sampled with ENABLE
//   PRICE_ADDR / PRICE_DATA   external synchronous price ROM (data valid one cycle after address)
//   BUSY, DONE, ERR, ERR_CODE command status; ERR_CODE held until the next DONE/ERR
//   TOTAL, LINE_COUNT, LOCKED basket state
//   RD_ID / RD_QTY            combinational debug read of the quantity table
module basket_accumulator #(
    parameter int NUM_PRODUCTS = 12,
    parameter int ID_W         = 4,
    parameter int QTY_W        = 4,
    parameter int PRICE_W      = 8,
    parameter int TOTAL_W      = 16,
    parameter int MAX_LINES    = 8
) (
    input  logic               CLOCK_50,
    input  logic               RESET_N,
    input  logic               ENABLE,
    input  logic [1:0]         CMD,
    input  logic [ID_W-1:0]    PRODUCT_ID,
    input  logic [QTY_W-1:0]   QUANTITY,
    output logic [ID_W-1:0]    PRICE_ADDR,
    input  logic [PRICE_W-1:0] PRICE_DATA,
    output logic               BUSY,
    output logic               DONE,
    output logic               ERR,
    output logic [2:0]         ERR_CODE,
    output logic [TOTAL_W-1:0] TOTAL,
    output logic [ID_W:0]      LINE_COUNT,
    output logic               LOCKED,
    input  logic [ID_W-1:0]    RD_ID,
    output logic [QTY_W-1:0]   RD_QTY
);

    localparam int PROD_W = PRICE_W + QTY_W;
    localparam int SUM_W  = TOTAL_W + 1;

    localparam logic [ID_W:0]   NUM_IDS   = (ID_W+1)'(NUM_PRODUCTS);
    localparam logic [ID_W:0]   LINES_CAP = (ID_W+1)'(MAX_LINES);
    localparam logic [ID_W:0]   ONE_LINE  = (ID_W+1)'(1);
    localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_PRODUCTS - 1);
    localparam logic [ID_W-1:0] ONE_ID    = ID_W'(1);

    localparam logic [1:0] C_ADD = 2'b00;
    localparam logic [1:0] C_REM = 2'b01;
    localparam logic [1:0] C_CLR = 2'b10;

    localparam logic [2:0] E_NONE   = 3'd0;
    localparam logic [2:0] E_BAD_ID = 3'd1;
    localparam logic [2:0] E_QTY_OV = 3'd2;
    localparam logic [2:0] E_UNDER  = 3'd3;
    localparam logic [2:0] E_FULL   = 3'd4;
    localparam logic [2:0] E_TOT_OV = 3'd5;
    localparam logic [2:0] E_LOCKED = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ACCUM,
        S_CLEAR,
        S_LOCK
    } state_t;

    state_t state;

    logic [QTY_W-1:0] qty_tbl [NUM_PRODUCTS];

    // Command latched at acceptance; the price arrives two cycles later.
    logic [ID_W-1:0]  cmd_id;
    logic [QTY_W-1:0] cmd_qty;
    logic             cmd_rem;
    logic [ID_W-1:0]  clr_idx;

    logic id_bad;

    // ACCUM-stage evaluation
    logic [QTY_W-1:0]   old_qty;
    logic [QTY_W-1:0]   eff_qty;
    logic [QTY_W-1:0]   nxt_qty;
    logic [PROD_W-1:0]  delta;
    logic [SUM_W-1:0]   delta_ext;
    logic [QTY_W:0]     add_qty;
    logic [SUM_W-1:0]   add_total;
    logic [TOTAL_W-1:0] nxt_total;
    logic [ID_W:0]      nxt_lines;
    logic               acc_fail;
    logic [2:0]         acc_code;

    always_comb begin
        id_bad = ({1'b0, PRODUCT_ID} >= NUM_IDS);
    end

    always_comb begin
        RD_QTY = '0;
        if ({1'b0, RD_ID} < NUM_IDS) begin
            RD_QTY = qty_tbl[RD_ID];
        end
    end

    always_comb begin
        old_qty = qty_tbl[cmd_id];
        // A remove with zero quantity takes the whole line out.
        eff_qty = (cmd_rem && (cmd_qty == '0)) ? old_qty : cmd_qty;
        delta     = PROD_W'(PRICE_DATA) * PROD_W'(eff_qty);
        delta_ext = SUM_W'(delta);
        // One extra bit on both sums exposes overflow as a carry-out.
        add_qty   = {1'b0, old_qty} + {1'b0, eff_qty};
        add_total = {1'b0, TOTAL} + delta_ext;

        acc_fail  = 1'b0;
        acc_code  = E_NONE;
        nxt_qty   = old_qty;
        nxt_total = TOTAL;
        nxt_lines = LINE_COUNT;

        if (cmd_rem) begin
            if (eff_qty > old_qty) begin
                acc_fail = 1'b1;
                acc_code = E_UNDER;
            end else begin
                nxt_qty   = old_qty - eff_qty;
                // Prices never change, so the total always covers what is removed.
                nxt_total = TOTAL - delta_ext[TOTAL_W-1:0];
                if ((nxt_qty == '0) && (old_qty != '0)) begin
                    nxt_lines = LINE_COUNT - ONE_LINE;
                end
            end
        end else begin
            if (add_qty[QTY_W]) begin
                acc_fail = 1'b1;
                acc_code = E_QTY_OV;
            end else if ((old_qty == '0) && (eff_qty != '0) && (LINE_COUNT == LINES_CAP)) begin
                acc_fail = 1'b1;
                acc_code = E_FULL;
            end else if (add_total[TOTAL_W]) begin
                acc_fail = 1'b1;
                acc_code = E_TOT_OV;
            end else begin
                nxt_qty   = add_qty[QTY_W-1:0];
                nxt_total = add_total[TOTAL_W-1:0];
                if ((old_qty == '0) && (eff_qty != '0)) begin
                    nxt_lines = LINE_COUNT + ONE_LINE;
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= S_IDLE;
            PRICE_ADDR <= '0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            ERR        <= 1'b0;
            ERR_CODE   <= E_NONE;
            TOTAL      <= '0;
            LINE_COUNT <= '0;
            LOCKED     <= 1'b0;
            cmd_id     <= '0;
            cmd_qty    <= '0;
            cmd_rem    <= 1'b0;
            clr_idx    <= '0;
            for (int i = 0; i < NUM_PRODUCTS; i++) begin
                qty_tbl[i] <= '0;
            end
        end else begin
            DONE <= 1'b0;
            ERR  <= 1'b0;

            case (state)
                S_IDLE, S_LOCK: begin
                    if (ENABLE) begin
                        case (CMD)
                            C_ADD, C_REM: begin
                                if (id_bad) begin
                                    ERR      <= 1'b1;
                                    ERR_CODE <= E_BAD_ID;
                                end else if (state == S_LOCK) begin
                                    ERR      <= 1'b1;
                                    ERR_CODE <= E_LOCKED;
                                end else begin
                                    state      <= S_FETCH;
                                    BUSY       <= 1'b1;
                                    PRICE_ADDR <= PRODUCT_ID;
                                    cmd_id     <= PRODUCT_ID;
                                    cmd_qty    <= QUANTITY;
                                    cmd_rem    <= (CMD == C_REM);
                                end
                            end
                            C_CLR: begin
                                state   <= S_CLEAR;
                                BUSY    <= 1'b1;
                                clr_idx <= '0;
                            end
                            default: begin
                                if (state == S_LOCK) begin
                                    ERR      <= 1'b1;
                                    ERR_CODE <= E_LOCKED;
                                end else begin
                                    DONE     <= 1'b1;
                                    ERR_CODE <= E_NONE;
                                    LOCKED   <= 1'b1;
                                    state    <= S_LOCK;
                                end
                            end
                        endcase
                    end
                end

                // ROM address was registered on entry; data is valid next cycle.
                S_FETCH: begin
                    state <= S_ACCUM;
                end

                S_ACCUM: begin
                    state <= S_IDLE;
                    BUSY  <= 1'b0;
                    if (acc_fail) begin
                        ERR      <= 1'b1;
                        ERR_CODE <= acc_code;
                    end else begin
                        DONE            <= 1'b1;
                        ERR_CODE        <= E_NONE;
                        qty_tbl[cmd_id] <= nxt_qty;
                        TOTAL           <= nxt_total;
                        LINE_COUNT      <= nxt_lines;
                    end
                end

                // One table entry per cycle; the aggregates go to zero up front.
                S_CLEAR: begin
                    qty_tbl[clr_idx] <= '0;
                    if (clr_idx == '0) begin
                        TOTAL      <= '0;
                        LINE_COUNT <= '0;
                    end
                    if (clr_idx == LAST_ID) begin
                        state    <= S_IDLE;
                        BUSY     <= 1'b0;
                        DONE     <= 1'b1;
                        ERR_CODE <= E_NONE;
                        LOCKED   <= 1'b0;
                    end else begin
                        clr_idx <= clr_idx + ONE_ID;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_basket_accumulator.sv
// Purpose: self-checking bench for basket_accumulator against a queue-free arithmetic basket model.
// Latency: each command is followed until DONE/ERR or a bounded cycle budget.
// Backpressure: exercises ENABLE during FETCH and reset during ACCUM.
module tb_basket_accumulator;

    localparam int NP        = 12;
    localparam int QMAX      = 15;
    localparam int TMAX      = 65535;
    localparam int MAXL      = 8;
    localparam int LAT_LIMIT = 40;

    localparam logic [1:0] C_ADD = 2'b00;
    localparam logic [1:0] C_REM = 2'b01;
    localparam logic [1:0] C_CLR = 2'b10;
    localparam logic [1:0] C_CHK = 2'b11;

    logic        CLOCK_50;
    logic        RESET_N;
    logic        ENABLE;
    logic [1:0]  CMD;
    logic [3:0]  PRODUCT_ID;
    logic [3:0]  QUANTITY;
    logic [3:0]  PRICE_ADDR;
    logic [7:0]  PRICE_DATA;
    logic        BUSY;
    logic        DONE;
    logic        ERR;
    logic [2:0]  ERR_CODE;
    logic [15:0] TOTAL;
    logic [4:0]  LINE_COUNT;
    logic        LOCKED;
    logic [3:0]  RD_ID;
    logic [3:0]  RD_QTY;

    basket_accumulator #(
        .NUM_PRODUCTS(12), .ID_W(4), .QTY_W(4), .PRICE_W(8), .TOTAL_W(16), .MAX_LINES(8)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .RESET_N   (RESET_N),
        .ENABLE    (ENABLE),
        .CMD       (CMD),
        .PRODUCT_ID(PRODUCT_ID),
        .QUANTITY  (QUANTITY),
        .PRICE_ADDR(PRICE_ADDR),
        .PRICE_DATA(PRICE_DATA),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .ERR       (ERR),
        .ERR_CODE  (ERR_CODE),
        .TOTAL     (TOTAL),
        .LINE_COUNT(LINE_COUNT),
        .LOCKED    (LOCKED),
        .RD_ID     (RD_ID),
        .RD_QTY    (RD_QTY)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    // Synchronous price ROM
    logic [7:0] rom [16];
    initial PRICE_DATA = 8'd0;
    always @(posedge CLOCK_50) PRICE_DATA <= rom[PRICE_ADDR];

    logic both_seen = 1'b0;
    always @(negedge CLOCK_50) if (DONE === 1'b1 && ERR === 1'b1) both_seen = 1'b1;

    int n_pass  = 0;
    int n_total = 0;

    // Basket reference model
    int qty_m [16];
    int total_m;
    bit locked_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    function automatic int lines_m();
        int n = 0;
        for (int i = 0; i < NP; i++) if (qty_m[i] != 0) n++;
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) qty_m[i] = 0;
        total_m  = 0;
        locked_m = 1'b0;
    endtask

    task automatic predict(input logic [1:0] c, input int id, input int q,
                           output logic e_err, output logic [2:0] e_code,
                           output int e_lat, output logic e_fetch);
        int eq;
        int p;
        int old;
        e_err = 1'b0; e_code = 3'd0; e_lat = 1; e_fetch = 1'b0;
        if (c == C_ADD || c == C_REM) begin
            if (id >= NP) begin
                e_err = 1'b1; e_code = 3'd1;
            end else if (locked_m) begin
                e_err = 1'b1; e_code = 3'd6;
            end else begin
                e_lat = 3; e_fetch = 1'b1;
                old = qty_m[4'(id)];
                p   = int'(rom[4'(id)]);
                eq  = (c == C_REM && q == 0) ? old : q;
                if (c == C_ADD) begin
                    if (old + eq > QMAX) begin
                        e_err = 1'b1; e_code = 3'd2;
                    end else if (old == 0 && eq > 0 && lines_m() == MAXL) begin
                        e_err = 1'b1; e_code = 3'd4;
                    end else if (total_m + p * eq > TMAX) begin
                        e_err = 1'b1; e_code = 3'd5;
                    end else begin
                        qty_m[4'(id)] = old + eq;
                        total_m += p * eq;
                    end
                end else begin
                    if (eq > old) begin
                        e_err = 1'b1; e_code = 3'd3;
                    end else begin
                        qty_m[4'(id)] = old - eq;
                        total_m -= p * eq;
                    end
                end
            end
        end else if (c == C_CLR) begin
            e_lat = NP + 1;
            model_reset();
        end else begin
            if (locked_m) begin
                e_err = 1'b1; e_code = 3'd6;
            end else begin
                locked_m = 1'b1;
            end
        end
    endtask

    task automatic issue(input logic [1:0] c, input int id, input int q,
                         output int lat, output logic got_done, output logic got_err,
                         output logic [2:0] code, output logic busy1, output logic [3:0] paddr1);
        CMD = c; PRODUCT_ID = 4'(id); QUANTITY = 4'(q); RD_ID = 4'(id); ENABLE = 1'b1;
        tick();
        ENABLE = 1'b0;
        lat = 1; busy1 = BUSY; paddr1 = PRICE_ADDR;
        while (DONE !== 1'b1 && ERR !== 1'b1 && lat < LAT_LIMIT) begin
            tick();
            lat++;
        end
        got_done = DONE; got_err = ERR; code = ERR_CODE;
    endtask

    task automatic run_cmd(input string tag, input logic [1:0] c, input int id, input int q);
        logic e_err, e_fetch, got_done, got_err, busy1;
        logic [2:0] e_code, code;
        logic [3:0] paddr1;
        int e_lat, lat;
        predict(c, id, q, e_err, e_code, e_lat, e_fetch);
        issue(c, id, q, lat, got_done, got_err, code, busy1, paddr1);
        check({tag, "_lat"},    32'(lat),      32'(e_lat));
        check({tag, "_done"},   32'(got_done), 32'(!e_err));
        check({tag, "_err"},    32'(got_err),  32'(e_err));
        check({tag, "_code"},   32'(code),     32'(e_code));
        check({tag, "_busy"},   32'(busy1),    32'(e_lat > 1));
        if (e_fetch) check({tag, "_paddr"}, 32'(paddr1), 32'(id));
        check({tag, "_total"},  32'(TOTAL),      32'(total_m));
        check({tag, "_lines"},  32'(LINE_COUNT), 32'(lines_m()));
        check({tag, "_locked"}, 32'(LOCKED),     32'(locked_m));
        check({tag, "_rdqty"},  32'(RD_QTY),     32'(qty_m[4'(id)]));
        tick();
        check({tag, "_pulse"},  32'(DONE | ERR), 32'(0));
    endtask

    task automatic check_reset(input string pfx);
        check({pfx, "_total"}, 32'(TOTAL),      32'(0));
        check({pfx, "_lines"}, 32'(LINE_COUNT), 32'(0));
        check({pfx, "_lock"},  32'(LOCKED),     32'(0));
        check({pfx, "_busy"},  32'(BUSY),       32'(0));
        check({pfx, "_done"},  32'(DONE),       32'(0));
        check({pfx, "_err"},   32'(ERR),        32'(0));
        check({pfx, "_code"},  32'(ERR_CODE),   32'(0));
        check({pfx, "_paddr"}, 32'(PRICE_ADDR), 32'(0));
        check({pfx, "_rdqty"}, 32'(RD_QTY),     32'(0));
    endtask

    initial begin
        int n_done;
        int n_err;
        int r;
        logic e_err, e_fetch;
        logic [2:0] e_code;
        int e_lat;

        for (int i = 0; i < 16; i++) rom[i] = 8'($urandom_range(1, 255));
        rom[3] = 8'd25;
        model_reset();
        RESET_N = 1'b0; ENABLE = 1'b0; CMD = C_ADD; PRODUCT_ID = 4'd0; QUANTITY = 4'd0; RD_ID = 4'd3;
        repeat (3) tick();
        check_reset("rst");
        RESET_N = 1'b1;
        tick();

        // Basic add, price 25 x 2
        run_cmd("tp1_add", C_ADD, 3, 2);
        check("tp1_total_50", 32'(TOTAL), 32'(50));
        check("tp1_lines_1",  32'(LINE_COUNT), 32'(1));

        // Quantity overflow then remove-all
        run_cmd("tp2_ovf", C_ADD, 3, 14);
        check("tp2_code_2", 32'(ERR_CODE), 32'(2));
        run_cmd("tp2_remall", C_REM, 3, 0);
        check("tp2_total_0", 32'(TOTAL), 32'(0));

        // Fill all lines, then one more distinct ID
        for (int i = 0; i < 8; i++) run_cmd("tp3_fill", C_ADD, i, 1);
        run_cmd("tp3_full", C_ADD, 8, 1);
        check("tp3_code_4", 32'(ERR_CODE), 32'(4));
        check("tp3_lines_8", 32'(LINE_COUNT), 32'(8));
        run_cmd("tp3_again", C_ADD, 0, 1);

        // Bad ID and underflow
        run_cmd("tp4_badid", C_ADD, 12, 1);
        check("tp4_code_1", 32'(ERR_CODE), 32'(1));
        run_cmd("tp4_under", C_REM, 5, 3);
        check("tp4_code_3", 32'(ERR_CODE), 32'(3));

        // Checkout lock and clear
        run_cmd("tp5_chk", C_CHK, 0, 0);
        run_cmd("tp5_locked_add", C_ADD, 1, 1);
        check("tp5_code_6", 32'(ERR_CODE), 32'(6));
        run_cmd("tp5_chk2", C_CHK, 0, 0);
        run_cmd("tp5_clr", C_CLR, 0, 0);
        check("tp5_unlocked", 32'(LOCKED), 32'(0));
        for (int i = 0; i < 16; i++) begin
            RD_ID = 4'(i);
            #1;
            check("tp5_rdqty_zero", 32'(RD_QTY), 32'(0));
        end

        // ENABLE during FETCH is ignored
        predict(C_ADD, 4, 1, e_err, e_code, e_lat, e_fetch);
        RD_ID = 4'd4; CMD = C_ADD; PRODUCT_ID = 4'd4; QUANTITY = 4'd1; ENABLE = 1'b1;
        tick();
        ENABLE = 1'b0;
        CMD = C_CHK; PRODUCT_ID = 4'd0; ENABLE = 1'b1;
        tick();
        ENABLE = 1'b0;
        n_done = 0; n_err = 0;
        for (int k = 0; k < 8; k++) begin
            n_done += int'(DONE);
            n_err  += int'(ERR);
            tick();
        end
        check("ign_done_cnt", 32'(n_done), 32'(!e_err));
        check("ign_err_cnt",  32'(n_err),  32'(e_err));
        check("ign_locked",   32'(LOCKED), 32'(locked_m));
        check("ign_total",    32'(TOTAL),  32'(total_m));
        check("ign_rdqty",    32'(RD_QTY), 32'(qty_m[4]));

        // Reset during ACCUM aborts with no response
        RD_ID = 4'd4; CMD = C_ADD; PRODUCT_ID = 4'd2; QUANTITY = 4'd3; ENABLE = 1'b1;
        tick();
        ENABLE = 1'b0;
        tick();
        check("rst_pre_busy", 32'(BUSY), 32'(1));
        RESET_N = 1'b0;
        #1;
        check_reset("rst_mid");
        n_done = 0; n_err = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_done += int'(DONE);
            n_err  += int'(ERR);
        end
        RESET_N = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_done += int'(DONE);
            n_err  += int'(ERR);
        end
        check("rst_no_done", 32'(n_done), 32'(0));
        check("rst_no_err",  32'(n_err),  32'(0));
        model_reset();

        // Randomized command mix
        for (int i = 0; i < 200; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 50)      run_cmd("rnd_add", C_ADD, int'($urandom_range(0, 13)), int'($urandom_range(0, 15)));
            else if (r < 88) run_cmd("rnd_rem", C_REM, int'($urandom_range(0, 13)), int'($urandom_range(0, 7)));
            else if (r < 94) run_cmd("rnd_chk", C_CHK, 0, 0);
            else             run_cmd("rnd_clr", C_CLR, 0, 0);
        end

        check("never_done_and_err", 32'(both_seen), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/basket_accumulator.md
Name: basket_accumulator

Overview:
Parametrised basket/checkout engine for the sale terminal. It accepts add, remove, clear and checkout commands from the state machine. It keeps a per-product quantity table, fetches unit prices from an external synchronous price ROM, and maintains a running total and line count. It replaces the fixed single-product basket enable path with multi-product accounting, error reporting and a post-checkout lock.

Parameters:
NUM_PRODUCTS, 12, number of product IDs (0..NUM_PRODUCTS-1)
ID_W, 4, product ID width; must satisfy 2^ID_W >= NUM_PRODUCTS
QTY_W, 4, per-product quantity width; QMAX = 2^QTY_W-1
PRICE_W, 8, unit price width
TOTAL_W, 16, running total width; TMAX = 2^TOTAL_W-1
MAX_LINES, 8, maximum number of distinct products with nonzero quantity

Ports:
CLOCK_50  in  1  system clock, rising edge
RESET_N  in  1  asynchronous active-low reset
ENABLE  in  1  one-cycle command strobe
CMD  in  2  00 add, 01 remove, 10 clear, 11 checkout
PRODUCT_ID  in  ID_W  target product, sampled with ENABLE
QUANTITY  in  QTY_W  amount, sampled with ENABLE
PRICE_ADDR  out  ID_W  price ROM address, registered
PRICE_DATA  in  PRICE_W  price ROM data, valid 1 cycle after PRICE_ADDR
BUSY  out  1  command in progress
DONE  out  1  one-cycle pulse, command completed successfully
ERR  out  1  one-cycle pulse, command rejected
ERR_CODE  out  3  held until next DONE/ERR: 0 none, 1 bad ID, 2 qty overflow, 3 underflow, 4 basket full, 5 total overflow, 6 locked
TOTAL  out  TOTAL_W  running basket total
LINE_COUNT  out  ID_W+1  number of IDs with nonzero quantity
LOCKED  out  1  high after checkout
RD_ID  in  ID_W  debug/VGA read index
RD_QTY  out  QTY_W  combinational quantity of RD_ID; 0 if RD_ID >= NUM_PRODUCTS

Behaviour:
- Reset values: all quantities 0, TOTAL 0, LINE_COUNT 0, LOCKED 0, BUSY 0, DONE 0, ERR 0, ERR_CODE 0, PRICE_ADDR 0, FSM in IDLE.
- States: IDLE, FETCH, ACCUM, CLEAR, LOCK.
- ENABLE is accepted only in IDLE or LOCK. ENABLE while BUSY is silently ignored: no pulse, no state change.
- Error checks on an add/remove accepted at cycle T:
  - PRODUCT_ID >= NUM_PRODUCTS -> ERR at T+1, code 1, no fetch.
  - In LOCK -> ERR at T+1, code 6.
- Add/remove timing from acceptance at T:
  - T+1: FETCH, BUSY=1, PRICE_ADDR=PRODUCT_ID.
  - T+2: ACCUM, PRICE_DATA sampled, delta = price*q computed at PRICE_W+QTY_W bits, then zero-extended to TOTAL_W+1.
  - T+3: table, TOTAL and LINE_COUNT updated and DONE pulses, or ERR pulses with nothing changed. BUSY=0, back to IDLE.
- Add rules, with old = current quantity and q = QUANTITY:
  - old+q > QMAX -> code 2.
  - old==0, q>0 and LINE_COUNT==MAX_LINES -> code 4.
  - TOTAL+delta > TMAX -> code 5.
  - q==0 -> DONE with no change.
  - LINE_COUNT increments when old==0 and q>0.
- Remove rules:
  - QUANTITY==0 means remove all, q=old.
  - q > old -> code 3.
  - A remove-all with old==0 -> DONE with no change.
  - TOTAL decreases by delta and never goes negative, because prices are constant.
  - LINE_COUNT decrements when the new quantity is 0 and old > 0.
- Check order when several errors apply: 1, 6, 2/3, 4, 5. Only the first is reported.
- Clear (accepted in IDLE or LOCK):
  - Enter CLEAR with BUSY=1 and zero one table entry per cycle, index 0..NUM_PRODUCTS-1.
  - TOTAL and LINE_COUNT are zeroed on the first CLEAR cycle.
  - After the last entry: DONE, LOCKED=0, IDLE.
  - Latency: DONE at T+NUM_PRODUCTS+1.
- Checkout:
  - From IDLE: DONE at T+1, LOCKED=1, state LOCK, and TOTAL/table frozen.
  - Checkout from LOCK -> ERR code 6.
- Asserting RESET_N low mid-command aborts immediately to the reset values. No DONE/ERR is produced.
- DONE and ERR are never high in the same cycle.

Test Plan:
- Reset, then add id 3 q 2 with price[3]=25 -> PRICE_ADDR=3 at T+1, DONE at T+3, TOTAL=50, LINE_COUNT=1, RD_QTY(3)=2.
- Add id 3 q 14 on top of qty 2 -> ERR code 2 at T+3, TOTAL stays 50. Then remove id 3 q 0 -> DONE, TOTAL=0, LINE_COUNT=0.
- With MAX_LINES=8, add ids 0..7 q 1 each, then add id 8 q 1 -> ninth command gives ERR code 4, LINE_COUNT=8. Adding id 0 q 1 again -> DONE.
- Add id 12 -> ERR code 1 at T+1, BUSY never rises. Remove id 5 q 3 when qty is 1 -> ERR code 3.
- Checkout, then add id 1 -> LOCKED=1, ERR code 6. Clear -> DONE at T+13, TOTAL=0, LOCKED=0, all RD_QTY=0.
- Pulse ENABLE during FETCH: the second command is ignored. Drive RESET_N low during ACCUM -> all outputs read their reset values, with no DONE/ERR pulse.
